multicycle_control: RTL and testbench

Parametrised multi-cycle control sequencer. It latches one instruction opcode per fetch handshake, decodes it, then steps through EXEC, MEM and WB states. It drives registered datapath strobes: RegWrite, MemWrite, MemtoReg, ALUSrc, Branch, How_high and ALUOp. It waits on a data-memory req/ack handshake, and sits between the instruction ROM/PC and the ALU/reg_file/data_mem datapath.

---
 rtl/multicycle_control.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
`timescale 1ns/1ps
`default_nettype none
// ==== multicycle_control : FETCH/DECODE/EXEC/MEM/WB/HALT opcode sequencer ====
// ==== registered datapath strobes, data-memory req/ack with timeout | rev 1.0 ==
module multicycle_control #(
    parameter int OPWIDTH     = 3,
    parameter int MCODEBITS   = 5,
    parameter int HHBITS      = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [MCODEBITS-1:0] instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic                 pc_en,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 MemtoReg,
    output logic                 ALUSrc,
    output logic                 Branch,
    output logic [HHBITS-1:0]    How_high,
    output logic [OPWIDTH-1:0]   ALUOp,
    output logic                 halted,
    output logic                 timeout_err
);

    localparam int                   C_CNTW     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [C_CNTW-1:0]    C_CNT_LAST = C_CNTW'(MEM_TIMEOUT - 1);
    localparam logic [C_CNTW-1:0]    C_CNT_MAX  = C_CNTW'(MEM_TIMEOUT);
    localparam logic [MCODEBITS-1:0] C_OP_STORE = MCODEBITS'(0);
    localparam logic [MCODEBITS-1:0] C_OP_ADD   = MCODEBITS'(1);
    localparam logic [MCODEBITS-1:0] C_OP_LOAD  = MCODEBITS'(2);
    localparam logic [MCODEBITS-1:0] C_OP_HALT  = {3'b110, {(MCODEBITS-3){1'b1}}};

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t               r_state;
    logic [MCODEBITS-1:0] r_op;
    logic [C_CNTW-1:0]    r_cnt;
    logic                 r_instr_ready;
    logic                 r_mem_req;
    logic                 r_pc_en;
    logic                 r_reg_write;
    logic                 r_mem_write;
    logic                 r_mem_to_reg;
    logic                 r_alu_src;
    logic                 r_branch;
    logic [HHBITS-1:0]    r_how_high;
    logic [OPWIDTH-1:0]   r_alu_op;
    logic                 r_halted;
    logic                 r_timeout_err;

    logic [1:0]           w_top2;
    logic [2:0]           w_top3;
    logic                 w_is_store;
    logic                 w_is_load;
    logic                 w_is_mem;
    logic                 w_is_alu;
    logic                 w_is_branch;
    logic                 w_is_halt;
    logic                 w_is_nop;
    logic [OPWIDTH-1:0]   w_alu_op;
    logic                 w_alu_src;
    logic                 w_mem_to_reg;
    logic                 w_branch;
    logic [HHBITS-1:0]    w_how_high;

    assign w_top2      = r_op[MCODEBITS-1 -: 2];
    assign w_top3      = r_op[MCODEBITS-1 -: 3];
    assign w_is_store  = (r_op == C_OP_STORE);
    assign w_is_load   = (r_op == C_OP_LOAD);
    assign w_is_mem    = w_is_store | w_is_load;
    assign w_is_alu    = (r_op == C_OP_ADD) | (w_top2 == 2'b01) | (w_top2 == 2'b10);
    assign w_is_branch = (w_top3 == 3'b111);
    assign w_is_halt   = (r_op == C_OP_HALT);
    assign w_is_nop    = ~(w_is_mem | w_is_alu | w_is_branch | w_is_halt);

    // Non-ALU opcodes leave the ALU in pass-through so the address path sees a+0.
    always_comb begin
        w_alu_op     = '1;
        w_alu_src    = 1'b0;
        w_mem_to_reg = w_is_load;
        w_branch     = w_is_branch;
        w_how_high   = '0;
        if (r_op == C_OP_ADD) begin
            w_alu_op = '0;
        end else if (w_is_alu) begin
            w_alu_op  = r_op[OPWIDTH-1:0];
            w_alu_src = (w_top2 == 2'b10);
        end
        if (w_is_branch) begin
            w_how_high = r_op[HHBITS-1:0];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state       <= S_FETCH;
            r_op          <= '0;
            r_cnt         <= '0;
            r_instr_ready <= 1'b0;
            r_mem_req     <= 1'b0;
            r_pc_en       <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_alu_src     <= 1'b0;
            r_branch      <= 1'b0;
            r_how_high    <= '0;
            r_alu_op      <= '1;
            r_halted      <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_pc_en     <= 1'b0;
            r_reg_write <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (r_instr_ready && instr_valid) begin
                        r_op          <= instr;
                        r_instr_ready <= 1'b0;
                        r_state       <= S_DECODE;
                    end else begin
                        r_instr_ready <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_alu_op     <= w_alu_op;
                    r_alu_src    <= w_alu_src;
                    r_mem_to_reg <= w_mem_to_reg;
                    r_branch     <= w_branch;
                    r_how_high   <= w_how_high;
                    // Branch/NOP strobe pc_en during EXEC, so it is armed here.
                    r_pc_en      <= w_is_branch | w_is_nop;
                    r_state      <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_is_mem) begin
                        r_mem_req   <= 1'b1;
                        r_mem_write <= w_is_store;
                        r_cnt       <= '0;
                        r_state     <= S_MEM;
                    end else if (w_is_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else if (w_is_alu) begin
                        r_reg_write <= 1'b1;
                        r_pc_en     <= 1'b1;
                        r_state     <= S_WB;
                    end else begin
                        r_instr_ready <= 1'b1;
                        r_state       <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_pc_en     <= 1'b1;
                        if (w_is_store) begin
                            r_instr_ready <= 1'b1;
                            r_state       <= S_FETCH;
                        end else begin
                            r_reg_write <= 1'b1;
                            r_state     <= S_WB;
                        end
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_mem_req     <= 1'b0;
                        r_mem_write   <= 1'b0;
                        r_cnt         <= C_CNT_MAX;
                        r_instr_ready <= 1'b1;
                        r_state       <= S_FETCH;
                    end else if (r_cnt != C_CNT_MAX) begin
                        r_cnt <= r_cnt + C_CNTW'(1);
                    end
                end
                S_WB: begin
                    r_instr_ready <= 1'b1;
                    r_state       <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_instr_ready <= 1'b0;
                    r_state       <= S_FETCH;
                end
            endcase
        end
    end

    assign instr_ready = r_instr_ready;
    assign mem_req     = r_mem_req;
    assign pc_en       = r_pc_en;
    assign RegWrite    = r_reg_write;
    assign MemWrite    = r_mem_write;
    assign MemtoReg    = r_mem_to_reg;
    assign ALUSrc      = r_alu_src;
    assign Branch      = r_branch;
    assign How_high    = r_how_high;
    assign ALUOp       = r_alu_op;
    assign halted      = r_halted;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
`default_nettype none
// ==== tb_multicycle_control : scoreboard bench, random opcodes + memory latency ====
// ==== expected per-instruction behaviour comes from an opcode-class model | rev 1.0
module tb_multicycle_control;

    localparam int T_OUT = 15;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [4:0] instr = '0;
    logic       instr_valid = 1'b0;
    logic       mem_ack = 1'b0;
    logic       instr_ready, mem_req, pc_en, RegWrite, MemWrite, MemtoReg;
    logic       ALUSrc, Branch, halted, timeout_err;
    logic [1:0] How_high;
    logic [2:0] ALUOp;

    multicycle_control #(
        .OPWIDTH(3), .MCODEBITS(5), .HHBITS(2), .MEM_TIMEOUT(T_OUT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .mem_ack(mem_ack), .mem_req(mem_req),
        .pc_en(pc_en), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .Branch(Branch),
        .How_high(How_high), .ALUOp(ALUOp), .halted(halted),
        .timeout_err(timeout_err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        int lat; int pc_cnt; int pc_idx; int rw_cnt; int rw_idx;
        int mr_cnt; int mw_cnt; int to; int hl;
        int aluop; int alusrc; int mtr; int br; int hh;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   mem_delay = 0;
    bit   model_to = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Cycle indices are relative to the accept cycle (index 0).
    function automatic rec_t model(input int op, input int d, inout bit sticky);
        rec_t r;
        int   m;
        bit   to;
        r = '0;
        r.pc_idx = -1;
        r.rw_idx = -1;
        r.aluop  = 7;
        if (op == 27) begin
            r.lat = 3;
            r.hl  = 1;
        end else if (op == 0 || op == 2) begin
            to = (d >= T_OUT);
            m  = to ? T_OUT : d + 1;
            r.mr_cnt = m;
            if (op == 0) r.mw_cnt = m;
            else         r.mtr = 1;
            if (to) begin
                r.lat  = 3 + T_OUT;
                sticky = 1'b1;
            end else if (op == 0) begin
                r.pc_cnt = 1; r.pc_idx = 4 + d; r.lat = 4 + d;
            end else begin
                r.pc_cnt = 1; r.pc_idx = 4 + d;
                r.rw_cnt = 1; r.rw_idx = 4 + d;
                r.lat    = 5 + d;
            end
        end else if (op == 1 || op / 8 == 1 || op / 8 == 2) begin
            r.aluop  = (op == 1) ? 0 : op % 8;
            r.alusrc = (op / 8 == 2) ? 1 : 0;
            r.pc_cnt = 1; r.pc_idx = 3;
            r.rw_cnt = 1; r.rw_idx = 3;
            r.lat    = 4;
        end else if (op / 4 == 7) begin
            r.br = 1; r.hh = op % 4;
            r.pc_cnt = 1; r.pc_idx = 2; r.lat = 3;
        end else begin
            r.pc_cnt = 1; r.pc_idx = 2; r.lat = 3;
        end
        r.to = sticky ? 1 : 0;
        return r;
    endfunction

    task automatic compare(input rec_t o, input rec_t e);
        check("latency", o.lat, e.lat);
        check("pc_en_count", o.pc_cnt, e.pc_cnt);
        check("pc_en_cycle", o.pc_idx, e.pc_idx);
        check("regwrite_count", o.rw_cnt, e.rw_cnt);
        check("regwrite_cycle", o.rw_idx, e.rw_idx);
        check("mem_req_cycles", o.mr_cnt, e.mr_cnt);
        check("memwrite_cycles", o.mw_cnt, e.mw_cnt);
        check("timeout_err", o.to, e.to);
        check("halted", o.hl, e.hl);
        check("ALUOp", o.aluop, e.aluop);
        check("ALUSrc", o.alusrc, e.alusrc);
        check("MemtoReg", o.mtr, e.mtr);
        check("Branch", o.br, e.br);
        check("How_high", o.hh, e.hh);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Memory model: acks after mem_delay wait cycles; stray acks while idle.
    initial begin : responder
        int waited;
        waited = 0;
        forever begin
            tick();
            if (!Reset) begin
                mem_ack = 1'b0; waited = 0;
            end else if (mem_req) begin
                mem_ack = (waited == mem_delay); waited++;
            end else begin
                mem_ack = ($urandom_range(0, 3) == 0); waited = 0;
            end
        end
    end

    initial begin : monitor
        bit   busy;
        int   rel;
        rec_t o;
        rec_t e;
        busy = 1'b0;
        rel  = 0;
        o    = '0;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    rel++;
                    if (mem_req) begin
                        o.mr_cnt++;
                        if (MemWrite) o.mw_cnt++;
                    end
                    if (pc_en)    begin o.pc_cnt++; o.pc_idx = rel; end
                    if (RegWrite) begin o.rw_cnt++; o.rw_idx = rel; end
                    if (rel == 2) begin
                        o.aluop = int'(ALUOp); o.alusrc = int'(ALUSrc);
                        o.mtr = int'(MemtoReg); o.br = int'(Branch);
                        o.hh = int'(How_high);
                    end
                    if (instr_ready || halted || rel > 100) begin
                        o.lat = rel; o.to = int'(timeout_err); o.hl = int'(halted);
                        busy = 1'b0;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL scoreboard: got completion, expected none queued");
                        end else begin
                            e = exp_q.pop_front();
                            compare(o, e);
                        end
                    end
                end
                if (!busy && instr_ready && instr_valid) begin
                    busy = 1'b1; rel = 0; o = '0; o.pc_idx = -1; o.rw_idx = -1;
                end
            end
        end
    end

    task automatic issue(input int op, input int d, input bit push);
        int budget;
        budget = 0;
        while (!instr_ready && budget < 200) begin
            instr = 5'($urandom); instr_valid = 1'($urandom);
            tick(); budget++;
        end
        instr_valid = 1'b0;
        if (!instr_ready) begin
            n_checks++;
            $display("FAIL issue_ready: got instr_ready=0, expected 1");
            return;
        end
        repeat ($urandom_range(0, 2)) tick();
        mem_delay = d;
        if (push) exp_q.push_back(model(op, d, model_to));
        instr = 5'(op); instr_valid = 1'b1;
        tick();
        instr = 5'($urandom); instr_valid = 1'($urandom);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        instr_valid = 1'b0;
        #1;
        check("rst_instr_ready", int'(instr_ready), 0);
        check("rst_mem_req", int'(mem_req), 0);
        check("rst_pc_en", int'(pc_en), 0);
        check("rst_RegWrite", int'(RegWrite), 0);
        check("rst_MemWrite", int'(MemWrite), 0);
        check("rst_MemtoReg", int'(MemtoReg), 0);
        check("rst_ALUSrc", int'(ALUSrc), 0);
        check("rst_Branch", int'(Branch), 0);
        check("rst_How_high", int'(How_high), 0);
        check("rst_ALUOp", int'(ALUOp), 7);
        check("rst_halted", int'(halted), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        model_to = 1'b0;
        tick(); tick();
        Reset = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int op, r, d, cnt, budget;
        repeat (2) tick();
        do_reset();
        // Directed: ADD, ALU-imm, branch, LOAD wait 3, STORE immediate, STORE timeout,
        // ADD after timeout, LOAD acked on the last allowed cycle, STORE one cycle late.
        issue(1, 0, 1);
        issue(21, 0, 1);
        issue(30, 0, 1);
        issue(2, 3, 1);
        issue(0, 0, 1);
        issue(0, 1000, 1);
        issue(1, 0, 1);
        issue(2, T_OUT - 1, 1);
        issue(0, T_OUT, 1);
        issue(3, 0, 1);
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 31);
            if (op == 27) op = 26;
            r = $urandom_range(0, 9);
            if (r < 7)       d = $urandom_range(0, 4);
            else if (r == 7) d = T_OUT - 1;
            else if (r == 8) d = T_OUT;
            else             d = 1000;
            issue(op, d, 1);
        end

        // Reset in the middle of a LOAD's memory wait: no write-back may follow.
        issue(2, 1000, 0);
        instr_valid = 1'b0;
        budget = 0;
        while (!mem_req && budget < 50) begin tick(); budget++; end
        check("mid_mem_reached", int'(mem_req), 1);
        repeat (4) tick();
        do_reset();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (RegWrite || pc_en) cnt++;
        end
        check("no_strobe_after_reset", cnt, 0);

        // HALT: ready must stay low despite valid instructions.
        issue(27, 0, 1);
        for (int i = 0; i < 25; i++) begin
            instr = 5'($urandom); instr_valid = 1'b1; tick();
        end
        check("halt_instr_ready", int'(instr_ready), 0);
        check("halt_flag", int'(halted), 1);
        check("halt_completed", exp_q.size(), 0);
        do_reset();
        issue(1, 0, 1);

        instr_valid = 1'b0;
        budget = 0;
        while ((exp_q.size() != 0 || !instr_ready) && budget < 300) begin
            tick(); budget++;
        end
        tick();
        check("drain_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
